// File: rtl/cfg_if_packer.sv
// rtl/cfg_if_packer.sv - packs pad beats into configuration words and buffers them for the CCU
// Optional parity checking of pad beats is enabled by defining CFG_IF_PARITY_EN.
module cfg_if_packer #(
  parameter int PORT_WIDTH      = 128,
  parameter int IN_WIDTH        = 32,
  parameter int FIFO_ADDR_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       PADIF_val,
  input  logic [IN_WIDTH-1:0]        PADIF_data,
`ifdef CFG_IF_PARITY_EN
  input  logic                       PADIF_par,
  output logic                       IFCCU_par_err,
`endif
  output logic                       IFPAD_rdy,
  input  logic                       CCUIF_flush,
  output logic                       IFCFG_val,
  output logic [PORT_WIDTH-1:0]      IFCFG_data,
  input  logic                       CFGIF_rdy,
  output logic [FIFO_ADDR_WIDTH:0]   IF_fifo_cnt
);

  localparam int RATIO = PORT_WIDTH / IN_WIDTH;
  localparam int BCW   = $clog2(RATIO);
  localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;
  localparam logic [BCW-1:0]           LAST_BEAT = BCW'(RATIO - 1);
  localparam logic [FIFO_ADDR_WIDTH:0] FULL_CNT  = (FIFO_ADDR_WIDTH + 1)'(DEPTH);

  logic [BCW-1:0]             beat_cnt;
  logic [PORT_WIDTH-1:0]      asm_q;
  logic [PORT_WIDTH-1:0]      word_next;
  logic [PORT_WIDTH-1:0]      mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
  logic [FIFO_ADDR_WIDTH:0]   cnt_q;

  logic last_beat;
  logic fifo_full;
  logic accept;
  logic word_ok;
  logic push;
  logic pop;

  assign last_beat = (beat_cnt == LAST_BEAT);
  assign fifo_full = (cnt_q == FULL_CNT);
  // The final beat of a word is only taken when a slot is already free, so
  // the CCU's ready never reaches the pad-side ready combinationally.
  assign IFPAD_rdy = !last_beat || !fifo_full;
  assign accept    = PADIF_val && IFPAD_rdy;

  assign IFCFG_val   = (cnt_q != '0);
  assign IFCFG_data  = mem[rd_ptr];
  assign IF_fifo_cnt = cnt_q;
  assign pop         = IFCFG_val && CFGIF_rdy;

`ifdef CFG_IF_PARITY_EN
  logic word_bad_q;
  logic par_err_q;
  logic beat_bad;
  logic word_bad;

  assign beat_bad      = ^{PADIF_data, PADIF_par};
  assign word_bad      = word_bad_q || beat_bad;
  assign word_ok       = !word_bad;
  assign IFCCU_par_err = par_err_q;

  always_ff @(posedge clk) begin
    if (reset || CCUIF_flush) begin
      word_bad_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else if (accept) begin
      if (last_beat) begin
        word_bad_q <= 1'b0;
        par_err_q  <= par_err_q || word_bad;
      end else begin
        word_bad_q <= word_bad;
      end
    end
  end
`else
  assign word_ok = 1'b1;
`endif

  assign push = accept && last_beat && word_ok;

  // Assembled word including the beat currently on the pad bus.
  always_comb begin
    word_next = asm_q;
    for (int k = 0; k < RATIO; k++) begin
      if (beat_cnt == BCW'(k)) begin
        word_next[k*IN_WIDTH +: IN_WIDTH] = PADIF_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      asm_q <= '0;
    end else if (!CCUIF_flush && accept) begin
      asm_q <= word_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || CCUIF_flush) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (!CCUIF_flush && push) begin
      mem[wr_ptr] <= word_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || CCUIF_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
